mul_div_sequencer: RTL and testbench
====================================

# mul_div_sequencer

Multi-cycle unsigned multiply/divide controller that sequences the shared add/subtract `alu` datapath. It performs one ALU operation per clock: a shift-add loop for multiply and a restoring shift-subtract loop for divide. It sits between the decode/execute stage and a single external `alu` instance, which it drives through `alu_a`/`alu_b`/`alu_cin` and reads back through `alu_result`/`alu_cout`.

## Interface

- DATA_BITS, 8, operand/result width; must match the connected `alu`.

- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  1  0 = multiply, 1 = divide; sampled with start.
- operand_a  in  DATA_BITS  multiplicand / dividend; sampled with start.
- operand_b  in  DATA_BITS  multiplier / divisor; sampled with start.
- busy  out  1  high while iterating (MUL or DIV state).
- done  out  1  one-cycle pulse: results valid.
- result_hi  out  DATA_BITS  product high half / remainder.
- result_lo  out  DATA_BITS  product low half / quotient.
- div_by_zero  out  1  set when a divide started with operand_b == 0; held with the results.
- alu_a  out  DATA_BITS  ALU operand a.
- alu_b  out  DATA_BITS  ALU operand b.
- alu_cin  out  1  ALU mode: 0 = add, 1 = subtract (a + ~b + 1).
- alu_result  in  DATA_BITS  ALU sum/difference; combinational from alu_a/alu_b/alu_cin.
- alu_cout  in  1  ALU carry; for subtract, 1 = no borrow (a >= b).

## Operation

- States: IDLE, MUL, DIV, DONE. Reset (reset_n = 0 at an edge) forces IDLE, zeroes hi/lo/divisor/counter and div_by_zero, and drops busy and done. This applies mid-operation too; the aborted operation produces no done.
- IDLE/DONE with start = 1: latch operands and clear div_by_zero.
  - op = 0: hi ← 0, lo ← operand_b, mcand ← operand_a, count ← DATA_BITS, go to MUL.
  - op = 1, operand_b ≠ 0: rem (hi) ← 0, quo (lo) ← operand_a, divisor ← operand_b, count ← DATA_BITS, go to DIV.
  - op = 1, operand_b = 0: hi ← operand_a, lo ← all ones, div_by_zero ← 1, go directly to DONE. No iterations.
- IDLE/DONE with start = 0: DONE → IDLE; IDLE stays.
- MUL iteration:
  - Drive alu_a = hi, alu_b = lo[0] ? mcand : 0, alu_cin = 0.
  - Update {hi, lo} ← {alu_cout, alu_result, lo} >> 1 (2·DATA_BITS+1 bits, keep low 2·DATA_BITS). Decrement count.
  - When count reaches 1 at the edge, go to DONE.
- DIV iteration (restoring):
  - Let msb = hi[DATA_BITS-1] and shifted = {hi[DATA_BITS-2:0], lo[DATA_BITS-1]}.
  - Drive alu_a = shifted, alu_b = divisor, alu_cin = 1.
  - If msb | alu_cout: hi ← alu_result and lo ← {lo[DATA_BITS-2:0], 1}.
  - Else: hi ← shifted and lo ← {lo[DATA_BITS-2:0], 0}.
  - Decrement count; when count reaches 1, go to DONE.
- In IDLE/DONE, alu_a = alu_b = 0 and alu_cin = 0.
- result_hi/result_lo are the hi/lo registers. They are final in DONE and hold unchanged through IDLE until the next accepted start.
- start while busy is ignored, and operands are not resampled.

## Timing

- busy = 1 exactly in MUL/DIV. done = 1 exactly in DONE. Both are Moore outputs.
- Reset values: busy 0, done 0, result_hi 0, result_lo 0, div_by_zero 0, alu_a 0, alu_b 0, alu_cin 0.
- start sampled at edge E0 → busy during cycles E0..E0+DATA_BITS (DATA_BITS cycles) → done high for the one cycle after edge E0+DATA_BITS.
- Divide-by-zero: done high in the cycle right after E0; busy never asserts.
- Back-to-back: start held high during DONE is accepted. The next operation begins with no IDLE cycle and done falls.
- The ALU path is combinational within one cycle. There is no registered ALU output.

## Test plan

- Multiply 13 × 11 (DATA_BITS = 8): busy for 8 cycles, then done; result_hi = 0x00, result_lo = 0x8F, div_by_zero = 0.
- Multiply 0xFF × 0xFF: result_hi = 0xFE, result_lo = 0x01. Check alu_cout capture on every iteration.
- Divide 200 / 7: result_lo = 0x1C, result_hi = 0x04. Divide 0xF0 / 0x81 (exercises the msb path): result_lo = 0x01, result_hi = 0x6F.
- Divide 0x55 / 0: done in the cycle after start, busy never high; result_lo = 0xFF, result_hi = 0x55, div_by_zero = 1. A following multiply 2 × 3 clears div_by_zero and gives 0x0006.
- Start pulses during busy with different operands are ignored; results match the first request. start held through DONE launches the next operation with no IDLE cycle.
- reset_n low for one edge at iteration 4 of a divide: next cycle all outputs are 0 and state is IDLE, with no done pulse. A new multiply 5 × 5 then yields 0x0019.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: unsigned shift-add multiply / restoring divide, one external add/sub ALU op per clock.
module mul_div_sequencer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [DATA_BITS-1:0] operand_a,
    input  logic [DATA_BITS-1:0] operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] result_hi,
    output logic [DATA_BITS-1:0] result_lo,
    output logic                 div_by_zero,
    output logic [DATA_BITS-1:0] alu_a,
    output logic [DATA_BITS-1:0] alu_b,
    output logic                 alu_cin,
    input  logic [DATA_BITS-1:0] alu_result,
    input  logic                 alu_cout
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 dbz_q, dbz_d;
    logic [DATA_BITS-1:0] shifted;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

    assign shifted = {hi_q[DATA_BITS-2:0], lo_q[DATA_BITS-1]};

    // opb_q holds the multiplicand for MUL and the divisor for DIV
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        count_d = count_q;
        dbz_d   = dbz_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (state_q == IDLE || state_q == DONE) begin
            if (start) begin
                dbz_d   = 1'b0;
                count_d = CW'(DATA_BITS);
                opb_d   = op ? operand_b : operand_a;
                if (!op) begin
                    hi_d    = '0;
                    lo_d    = operand_b;
                    state_d = MUL;
                end else if (operand_b != '0) begin
                    hi_d    = '0;
                    lo_d    = operand_a;
                    state_d = DIV;
                end else begin
                    hi_d    = operand_a;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end
            end else begin
                state_d = IDLE;
            end
        end else begin
            count_d = count_q - CW'(1);
            state_d = (count_q == CW'(1)) ? DONE : state_q;
            if (state_q == MUL) begin
                alu_a        = hi_q;
                alu_b        = lo_q[0] ? opb_q : '0;
                {hi_d, lo_d} = {alu_cout, alu_result, lo_q[DATA_BITS-1:1]};
            end else begin
                alu_a   = shifted;
                alu_b   = opb_q;
                alu_cin = 1'b1;
                hi_d    = (hi_q[DATA_BITS-1] | alu_cout) ? alu_result : shifted;
                lo_d    = {lo_q[DATA_BITS-2:0], hi_q[DATA_BITS-1] | alu_cout};
            end
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign result_hi   = hi_q;
    assign result_lo   = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: table vectors and scoreboard for mul_div_sequencer with a behavioural ALU.
module tb_mul_div_sequencer;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, op = 1'b0;
    logic [W-1:0] operand_a = '0, operand_b = '0;
    logic         busy, done, div_by_zero, alu_cin, alu_cout;
    logic [W-1:0] result_hi, result_lo, alu_a, alu_b, alu_result;
    logic [W:0]   alu_sum;
    logic [W-1:0] fa, fb;
    logic         fc;
    exp_t         sb[$];
    vec_t         tbl[10];
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_cin ? ~alu_b : alu_b} + (W+1)'(alu_cin);
    assign alu_result = alu_sum[W-1:0];
    assign alu_cout   = alu_sum[W];

    mul_div_sequencer #(.DATA_BITS(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (!o) return '{p[2*W-1:W], p[W-1:0], 1'b0};
        if (b == '0) return '{a, {W{1'b1}}, 1'b1};
        return '{a % b, a / b, 1'b0};
    endfunction

    task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        sb.push_back(e);
        fa = o ? {{(W-1){1'b0}}, a[W-1]} : '0;
        fb = o ? b : (b[0] ? a : '0);
        fc = o;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit noise, input int lat);
        int n = 0;
        int nb = 0;
        exp_t e;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (n == 0 && busy) begin
                chk("alu_a_iter1", 32'(alu_a), 32'(fa));
                chk("alu_b_iter1", 32'(alu_b), 32'(fb));
                chk("alu_cin_iter1", 32'(alu_cin), 32'(fc));
            end
            if (noise && busy) begin
                start = 1'b1;
                op = 1'($urandom);
                operand_a = W'($urandom);
                operand_b = W'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(n), 32'(lat));
        chk("busy_cycles", 32'(nb), 32'(lat));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("result_hi", 32'(result_hi), 32'(e.hi));
            chk("result_lo", 32'(result_lo), 32'(e.lo));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        launch(o, a, b, e);
        wait_done(1'b0, (o && b == '0) ? 0 : W);
    endtask

    initial begin
        exp_t d;
        int dn;
        logic [W-1:0] held;
        tbl[0] = '{1'b0, 8'd13,  8'd11,  '{8'h00, 8'h8F, 1'b0}};
        tbl[1] = '{1'b0, 8'hFF,  8'hFF,  '{8'hFE, 8'h01, 1'b0}};
        tbl[2] = '{1'b1, 8'd200, 8'd7,   '{8'h04, 8'h1C, 1'b0}};
        tbl[3] = '{1'b1, 8'hF0,  8'h81,  '{8'h6F, 8'h01, 1'b0}};
        tbl[4] = '{1'b1, 8'h55,  8'h00,  '{8'h55, 8'hFF, 1'b1}};
        tbl[5] = '{1'b0, 8'd2,   8'd3,   '{8'h00, 8'h06, 1'b0}};
        tbl[6] = '{1'b0, 8'h00,  8'hA5,  '{8'h00, 8'h00, 1'b0}};
        tbl[7] = '{1'b1, 8'd7,   8'd200, '{8'h07, 8'h00, 1'b0}};
        tbl[8] = '{1'b1, 8'hFF,  8'h01,  '{8'h00, 8'hFF, 1'b0}};
        tbl[9] = '{1'b0, 8'h80,  8'h02,  '{8'h01, 8'h00, 1'b0}};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", 32'(result_hi), 32'd0);
        chk("rst_lo", 32'(result_lo), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_cin", 32'(alu_cin), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
            held = result_lo;
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_hold_lo", 32'(result_lo), 32'(held));
        end

        for (int i = 0; i < 16; i++) begin
            logic o;
            logic [W-1:0] a, b;
            o = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            run(o, a, b, model(o, a, b));
        end

        launch(1'b0, 8'd13, 8'd11, '{8'h00, 8'h8F, 1'b0});
        wait_done(1'b1, W);

        launch(1'b0, 8'd6, 8'd7, model(1'b0, 8'd6, 8'd7));
        wait_done(1'b0, W);
        launch(1'b1, 8'd100, 8'd9, model(1'b1, 8'd100, 8'd9));
        chk("b2b_done_fell", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(1'b0, W);
        @(negedge clk);

        launch(1'b1, 8'd200, 8'd7, model(1'b1, 8'd200, 8'd7));
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        d = sb.pop_back();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", 32'(result_hi), 32'd0);
        chk("abort_lo", 32'(result_lo), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        chk("abort_alu", 32'({alu_a, alu_b, alu_cin}), 32'd0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        run(1'b0, 8'd5, 8'd5, '{8'h00, 8'h19, 1'b0});

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
